// File: rtl/obf_lock_alu_if.sv
// Bus bundle for obf_lock_alu: operand/opcode in, masked accumulator and status out.
interface obf_lock_alu_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] datain;
  logic [1:0]        op;
  logic [DATA_W-1:0] dataout;
  logic              valid;
  logic              unlocked;

  modport master (output datain, output op, input dataout, input valid, input unlocked);
  modport slave  (input datain, input op, output dataout, output valid, output unlocked);
endinterface

// File: rtl/obf_lock_alu.sv
// FSM-locked accumulator core. Stays locked until the KEY_LEN-word key arrives
// on {op, datain}; while locked every output word is XOR-masked with an LFSR.
// Optional feature macro: OBF_LOCKOUT_EN (adds a tries counter and a terminal
// LOCKOUT state after MAX_TRIES non-idle mismatches).
module obf_lock_alu #(
  parameter int                                DATA_W    = 8,
  parameter int                                KEY_LEN   = 4,
  parameter logic [KEY_LEN*(DATA_W+2)-1:0]     KEY_SEQ   = {10'h0F1, 10'h37E, 10'h1C3, 10'h2A5},
  parameter int                                MAX_TRIES = 3,
  parameter logic [DATA_W-1:0]                 LFSR_SEED = 8'hB4
) (
  input logic             clk,
  input logic             rst,
  obf_lock_alu_if.slave   bus
);

  localparam int W     = DATA_W + 2;
  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
`ifdef OBF_LOCKOUT_EN
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
`endif

  typedef enum logic [1:0] {
    S_CHECK   = 2'd0,
    S_FUNC    = 2'd1
`ifdef OBF_LOCKOUT_EN
    ,
    S_LOCKOUT = 2'd2
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
`ifdef OBF_LOCKOUT_EN
  logic [TRY_W-1:0]    r_tries;
  logic [TRY_W-1:0]    w_tries_nxt;
  logic [TRY_W-1:0]    w_tries_inc;
`endif
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_lfsr;
  logic                r_valid;
  logic [W-1:0]        w_key;
  logic [W-1:0]        w_step;
  logic                w_unlocked;

  assign w_key      = {bus.op, bus.datain};
  assign w_unlocked = (r_state == S_FUNC);

  // Select the key word expected at the current sequence position
  always_comb begin
    w_step = '0;
    for (int unsigned i = 0; i < KEY_LEN; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_step = KEY_SEQ[i*W +: W];
      end
    end
  end

  // Unlock FSM state, key index and tries registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CHECK;
      r_idx   <= '0;
`ifdef OBF_LOCKOUT_EN
      r_tries <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
`ifdef OBF_LOCKOUT_EN
      r_tries <= w_tries_nxt;
`endif
    end
  end

  // Next-state logic: advance on match, ignore idle, restart on other mismatches
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
`ifdef OBF_LOCKOUT_EN
    w_tries_inc = r_tries + TRY_W'(1);
    w_tries_nxt = r_tries;
`endif
    case (r_state)
      S_CHECK: begin
        if (w_key == w_step) begin
          if (r_idx == IDX_W'(KEY_LEN - 1)) begin
            w_state_nxt = S_FUNC;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else if (w_key != '0) begin
          // the mismatching word is not retried as step 0
          w_idx_nxt = '0;
`ifdef OBF_LOCKOUT_EN
          w_tries_nxt = w_tries_inc;
          if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
            w_state_nxt = S_LOCKOUT;
          end
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath: accumulator, valid flag and free-running mask LFSR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      case (bus.op)
        2'b01:   r_acc <= bus.datain;
        2'b10:   r_acc <= r_acc + bus.datain;
        2'b11:   r_acc <= r_acc ^ bus.datain;
        default: r_acc <= r_acc;
      endcase
      r_valid <= (bus.op != 2'b00);
      r_lfsr  <= {r_lfsr[DATA_W-2:0], r_lfsr[DATA_W-1] ^ r_lfsr[DATA_W-2]};
    end
  end

  assign bus.dataout  = r_acc ^ (r_lfsr & {DATA_W{~w_unlocked}});
  assign bus.valid    = r_valid;
  assign bus.unlocked = w_unlocked;

endmodule

// File: tb/tb_obf_lock_alu.sv
// Self-checking bench for obf_lock_alu: directed key/op scenarios plus
// randomized traffic against a behavioural reference model.
module tb_obf_lock_alu;

  localparam int DATA_W    = 8;
  localparam int KEY_LEN   = 4;
  localparam int MAX_TRIES = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  obf_lock_alu_if #(.DATA_W(DATA_W)) bus ();

  obf_lock_alu #(.DATA_W(DATA_W), .KEY_LEN(KEY_LEN), .MAX_TRIES(MAX_TRIES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned key_words [KEY_LEN] = '{32'h2A5, 32'h1C3, 32'h37E, 32'h0F1};

  int unsigned m_acc, m_lfsr, m_idx, m_tries;
  bit          m_unl, m_lock, m_valid;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_lfsr = 32'hB4; m_idx = 0; m_tries = 0;
    m_unl = 0; m_lock = 0; m_valid = 0;
  endtask

  task automatic model_edge(input logic [1:0] op, input logic [7:0] d);
    int unsigned k;
    k = {22'd0, op, d};
    if (!m_unl && !m_lock) begin
      if (k == key_words[m_idx]) begin
        if (m_idx == KEY_LEN - 1) m_unl = 1;
        else m_idx++;
      end else if (k != 0) begin
        m_idx = 0;
`ifdef OBF_LOCKOUT_EN
        m_tries++;
        if (m_tries == MAX_TRIES) m_lock = 1;
`endif
      end
    end
    case (op)
      2'd1: m_acc = d;
      2'd2: m_acc = (m_acc + d) % 256;
      2'd3: m_acc = m_acc ^ d;
      default: ;
    endcase
    m_valid = (op != 0);
    m_lfsr  = ((m_lfsr * 2) % 256) | (((m_lfsr / 128) ^ (m_lfsr / 64)) % 2);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "/dataout"},  32'(bus.dataout), m_unl ? m_acc : (m_acc ^ m_lfsr));
    check_eq({tag, "/unlocked"}, 32'(bus.unlocked), 32'(m_unl));
    check_eq({tag, "/valid"},    32'(bus.valid), 32'(m_valid));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs checked there too.
  task automatic drive(input string tag, input logic [1:0] op, input logic [7:0] d);
    bus.op = op; bus.datain = d;
    @(posedge clk);
    model_edge(op, d);
    #1;
    check_model(tag);
  endtask

  task automatic drive_key(input string tag, input logic [9:0] k);
    drive(tag, k[9:8], k[7:0]);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_eq({tag, "/async_dataout"},  32'(bus.dataout), 32'hB4);
    check_eq({tag, "/async_unlocked"}, 32'(bus.unlocked), 0);
    check_eq({tag, "/async_valid"},    32'(bus.valid), 0);
    model_reset();
    bus.op = 2'd0; bus.datain = 8'd0;
    @(posedge clk);
    #1;
    check_model({tag, "/held"});
    rst = 1'b1;
  endtask

  task automatic send_full_key(input string tag);
    for (int i = 0; i < KEY_LEN; i++) drive_key(tag, key_words[i][9:0]);
  endtask

  initial begin
    logic [9:0] kw;
    int unsigned r, rst_at;
    bus.op = 2'd0; bus.datain = 8'd0;
    model_reset();

    // Power-on reset
    @(posedge clk);
    #1;
    check_eq("por_dataout", 32'(bus.dataout), 32'hB4);
    check_model("por");
    rst = 1'b1;

    // Correct key
    send_full_key("unlock");
    check_eq("unlock_flag", 32'(bus.unlocked), 1);
    check_eq("unlock_dataout", 32'(bus.dataout), 32'hBD);
    check_eq("unlock_valid", 32'(bus.valid), 0);

    // Unlocked ops
    drive("op_load", 2'b01, 8'h10);
    check_eq("op_load_val", 32'(bus.dataout), 32'h10);
    drive("op_add", 2'b10, 8'hF5);
    check_eq("op_add_val", 32'(bus.dataout), 32'h05);
    drive("op_xor", 2'b11, 8'hFF);
    check_eq("op_xor_val", 32'(bus.dataout), 32'hFA);
    check_eq("op_xor_valid", 32'(bus.valid), 1);
    drive("op_load5", 2'b01, 8'h05);

    // Asynchronous reset while unlocked with acc = 0x05
    do_reset("mid_rst");

    // Masked output before unlock
    drive("pre_load", 2'b01, 8'h10);
    check_eq("pre_masked", 32'(bus.dataout != 8'h10), 1);
    check_eq("pre_locked", 32'(bus.unlocked), 0);
    check_eq("pre_valid", 32'(bus.valid), 1);

    // Partial match restart; mismatching word is not step 0
    do_reset("part_rst");
    drive_key("part", 10'h2A5);
    drive_key("part", 10'h1C3);
    drive_key("part", 10'h2A5);
    drive_key("part_idle", 10'h000);
    send_full_key("part_key");
    check_eq("part_unlock", 32'(bus.unlocked), 1);

    // Three mismatches, then the correct key
    do_reset("try_rst");
    drive_key("try", 10'h001);
    drive_key("try", 10'h002);
    drive_key("try", 10'h003);
    send_full_key("try_key");
`ifdef OBF_LOCKOUT_EN
    check_eq("try_lockout", 32'(bus.unlocked), 0);
`else
    check_eq("try_unlimited", 32'(bus.unlocked), 1);
`endif

    // Randomized traffic with occasional mid-round resets
    for (int round = 0; round < 20; round++) begin
      do_reset("rnd_rst");
      rst_at = $urandom_range(10, 60);
      for (int c = 0; c < 40; c++) begin
        if (c == rst_at) do_reset("rnd_mid_rst");
        r = $urandom_range(0, 7);
        if (r < 4 && !m_unl) kw = key_words[m_idx][9:0];
        else if (r == 4)     kw = 10'h000;
        else                 kw = 10'($urandom);
        drive_key("rnd", kw);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obf_lock_alu.md
# obf_lock_alu

Parametrised FSM-locked accumulator core with a warm-up unlock sequence. It is the next generation of the toy obfuscated core.
- After reset, the block stays locked until a KEY_LEN-word key sequence arrives on consecutive non-idle cycles on {op, datain}.
- While locked, the datapath runs but every output word is XOR-masked with a free-running LFSR.
- It sits directly behind the stimulus/unlock driver and replaces the fixed-width toy core in the obfuscation benches.

## Interface
- DATA_W, 8, datapath width; key word width W = DATA_W+2
- KEY_LEN, 4, number of key words (≥1)
- KEY_SEQ, {10'h0F1,10'h37E,10'h1C3,10'h2A5}, KEY_LEN×W packed key; step i = KEY_SEQ[i*W +: W]; step 0 is in the LSBs
- MAX_TRIES, 3, non-idle mismatches allowed before lockout (≥1)
- LFSR_SEED, 8'hB4, DATA_W-bit LFSR reset value; must be nonzero
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- datain  input  DATA_W  operand / low key bits
- op  input  2  opcode / high key bits
- dataout  output  DATA_W  accumulator, masked unless unlocked
- valid  output  1  previous cycle executed a non-NOP op
- unlocked  output  1  FSM is in FUNC

## Operation
- States:
  - CHECK: reset state; idx = 0, tries = 0.
  - FUNC: unlocked.
  - LOCKOUT: terminal until reset.
- Key word k = {op, datain}. Idle word: k == 0.
- CHECK, evaluated at each edge:
  - k == step[idx] and idx == KEY_LEN-1 → FUNC.
  - k == step[idx] otherwise → idx+1.
  - Idle word not equal to step[idx] → no change.
  - Other mismatch → idx = 0 and tries+1; the mismatching word is not re-evaluated against step 0.
  - If tries+1 == MAX_TRIES → LOCKOUT.
- FUNC and LOCKOUT never leave their state except by reset.
- Datapath runs in every state; acc is DATA_W bits, modulo 2^DATA_W:
  - op 00: NOP
  - op 01: acc = datain
  - op 10: acc = acc + datain (carry dropped)
  - op 11: acc = acc ^ datain
- valid is registered: it is 1 in the cycle after any op ≠ 00, in any state.
- LFSR steps every cycle in all states: lfsr = {lfsr[DATA_W-2:0], lfsr[DATA_W-1]^lfsr[DATA_W-2]}. From a nonzero seed it never reaches zero.
- dataout = acc ^ (unlocked ? 0 : lfsr), combinational from registers only.
- Reset values:
  - state CHECK, idx 0, tries 0
  - acc 0, lfsr LFSR_SEED
  - valid 0, unlocked 0, dataout = LFSR_SEED

## Timing
- Inputs are sampled at the rising edge.
- Output latency is 1 cycle for both acc and valid.
- unlocked rises right after the edge that samples the final key word. The same edge updates acc with that word's op, so dataout is unmasked from that cycle on.
- On a key match, the state update and the datapath update happen together; the key word is also executed as an op.
- Reset asserted at any point (mid-sequence, in FUNC, in LOCKOUT) takes effect immediately and asynchronously:
  - All outputs return to their reset values.
  - Unlock progress is lost.
- Reset release is synchronous in effect: the first word is sampled at the first edge with rst high.

## Configuration
- OBF_LOCKOUT_EN defined:
  - tries counter and LOCKOUT state are present; behaviour is as above.
- OBF_LOCKOUT_EN undefined:
  - Neither tries nor LOCKOUT exists; MAX_TRIES is ignored.
  - A mismatch only resets idx to 0, and unlock attempts are unlimited.

## Test plan
- Correct key (defaults), rst released, then 2A5, 1C3, 37E, 0F1 → unlocked = 1 the cycle after 0F1, dataout = 8'hBD, valid = 0.
- After unlock, drive op 01/0x10, then op 10/0xF5, then op 11/0xFF → dataout 0x10, 0x05, 0xFA on successive cycles, valid = 1 each.
- Before unlock, drive op 01/0x10 → dataout = 0x10 ^ lfsr ≠ 0x10, unlocked = 0, valid = 1.
- Partial match restart: 2A5, 1C3, 2A5, then the full key → unlock after the full key; the third word does not count as step 0; tries = 1.
- With OBF_LOCKOUT_EN, three mismatches (0x001, 0x002, 0x003), then the correct key → unlocked stays 0 and dataout stays masked. Without OBF_LOCKOUT_EN, the same sequence → unlocked = 1.
- Reset mid-operation: pull rst low while unlocked with acc = 0x05 → unlocked = 0, valid = 0 and dataout = 0xB4 immediately, before the next edge.
